// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter granting one word per grant to an icache or dcache.
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   iREN, iaddr           icache read request and word address
//   dREN, dWEN            dcache read / write request
//   daddr, dstore         dcache word address and write data
//   iwait, dwait          1 = stall, 0 = word completes this cycle
//   iload, dload          read data returned to the caches (straight from ramload)
//   ramREN, ramWEN        RAM read / write enables
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and status (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
// Build option: define MEMORY_ARBITER_FAIR_EN to alternate priority between the caches
// using a last-grant flag; otherwise the dcache always wins a tie.
module memory_arbiter #(
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IGNT = 2'd1;
  localparam logic [1:0] DGNT = 2'd2;
  localparam logic [1:0] ACCESS = 2'd2;

  // CPUID only tags debug output in simulation builds; it has no hardware effect.
  if (CPUID < 0) begin : g_cpuid_tag
  end

  logic [1:0] state, next_state;
  logic       dreq, access, igr, dgr, i_first;

  assign dreq   = dREN | dWEN;
  assign access = ramstate == ACCESS;
  assign igr    = state == IGNT;
  assign dgr    = state == DGNT;

`ifdef MEMORY_ARBITER_FAIR_EN
  logic last_d;
  // Only a real completion (request still up when ACCESS arrives) moves the flag.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) last_d <= 1'b0;
    else if (dgr && dreq && access) last_d <= 1'b1;
    else if (igr && iREN && access) last_d <= 1'b0;
  assign i_first = last_d & iREN;
`else
  assign i_first = 1'b0;
`endif

  always_comb
    next_state = (state == IDLE) ? (i_first ? IGNT : dreq ? DGNT : iREN ? IGNT : IDLE)
               : igr ? ((iREN && !access) ? IGNT : IDLE)
               : dgr ? ((dreq && !access) ? DGNT : IDLE)
               : IDLE;

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= next_state;

  // A requester that is not asserting its request never stalls; a granted one is
  // released only in the ACCESS cycle.
  assign iwait    = iREN & ~(igr & access);
  assign dwait    = dreq & ~(dgr & access);
  assign ramREN   = igr ? iREN : dgr ? (dREN & ~dWEN) : 1'b0;
  assign ramWEN   = dgr & dWEN;
  assign ramaddr  = igr ? iaddr : dgr ? daddr : 32'h0;
  assign ramstore = dgr ? dstore : 32'h0;
  assign iload    = ramload;
  assign dload    = ramload;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector bench for memory_arbiter.
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  memory_arbiter #(.CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  rstate;
    logic [31:0] rload;
    logic        e_iwait;
    logic        e_dwait;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ew_i, input logic ew_d, input logic e_ren,
                          input logic e_wen, input logic [31:0] e_addr, input logic [31:0] e_store);
    chk({tag, " iwait"}, {31'b0, iwait}, {31'b0, ew_i});
    chk({tag, " dwait"}, {31'b0, dwait}, {31'b0, ew_d});
    chk({tag, " ramREN"}, {31'b0, ramREN}, {31'b0, e_ren});
    chk({tag, " ramWEN"}, {31'b0, ramWEN}, {31'b0, e_wen});
    chk({tag, " ramaddr"}, ramaddr, e_addr);
    chk({tag, " ramstore"}, ramstore, e_store);
  endtask

  initial begin
    //          iren iaddr  dren dwen daddr  dstore        rst   rload          iw dw ren wen addr   store
    vecs[0]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        2'd0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0};
    vecs[1]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        2'd2, 32'h1234ABCD, 1, 0, 0, 0, 32'h0,  32'h0};
    vecs[2]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        2'd1, 32'h0,        1, 0, 1, 0, 32'h40, 32'h0};
    vecs[3]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        2'd2, 32'h1234ABCD, 0, 0, 1, 0, 32'h40, 32'h0};
    vecs[4]  = '{0, 32'h0,  0, 1, 32'h80, 32'hDEADBEEF, 2'd0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0};
    vecs[5]  = '{0, 32'h0,  0, 1, 32'h80, 32'hDEADBEEF, 2'd1, 32'h0,        0, 1, 0, 1, 32'h80, 32'hDEADBEEF};
    vecs[6]  = '{0, 32'h0,  0, 1, 32'h80, 32'hDEADBEEF, 2'd1, 32'h0,        0, 1, 0, 1, 32'h80, 32'hDEADBEEF};
    vecs[7]  = '{0, 32'h0,  0, 1, 32'h80, 32'hDEADBEEF, 2'd1, 32'h0,        0, 1, 0, 1, 32'h80, 32'hDEADBEEF};
    vecs[8]  = '{0, 32'h0,  0, 1, 32'h80, 32'hDEADBEEF, 2'd2, 32'hCAFEF00D, 0, 0, 0, 1, 32'h80, 32'hDEADBEEF};
    vecs[9]  = '{0, 32'h0,  1, 1, 32'h90, 32'h55,       2'd0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0};
    vecs[10] = '{0, 32'h0,  1, 1, 32'h90, 32'h55,       2'd3, 32'h0,        0, 1, 0, 1, 32'h90, 32'h55};
    vecs[11] = '{1, 32'h44, 1, 0, 32'hA0, 32'h55,       2'd1, 32'h0,        1, 1, 1, 0, 32'hA0, 32'h55};
    vecs[12] = '{1, 32'h44, 0, 0, 32'hA0, 32'h55,       2'd2, 32'h77,       1, 0, 0, 0, 32'hA0, 32'h55};
    vecs[13] = '{1, 32'h44, 0, 0, 32'h0,  32'h0,        2'd0, 32'h0,        1, 0, 0, 0, 32'h0,  32'h0};
    vecs[14] = '{0, 32'h44, 0, 0, 32'h0,  32'h0,        2'd1, 32'h0,        0, 0, 0, 0, 32'h44, 32'h0};
    vecs[15] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        2'd0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0};

    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
    iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = 32'h0; ramstate = 2'd2;
    repeat (2) @(negedge CLK);
    chk_outs("reset", 1, 1, 0, 0, 32'h0, 32'h0);
    iREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    nRST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      iREN = vecs[i].iren; iaddr = vecs[i].iaddr;
      dREN = vecs[i].dren; dWEN = vecs[i].dwen;
      daddr = vecs[i].daddr; dstore = vecs[i].dstore;
      ramstate = vecs[i].rstate; ramload = vecs[i].rload;
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_iwait, vecs[i].e_dwait, vecs[i].e_ren,
               vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store);
      chk($sformatf("vec%0d iload", i), iload, vecs[i].rload);
      chk($sformatf("vec%0d dload", i), dload, vecs[i].rload);
    end

    // Reset pulsed while a dcache write is stalled in its grant.
    @(negedge CLK);
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = 2'd1;
    #2 chk_outs("rst_idle", 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    #1 chk_outs("rst_dgnt", 0, 1, 0, 1, 32'h80, 32'hDEADBEEF);
    nRST = 1'b0;
    #1 chk_outs("rst_async", 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    ramstate = 2'd2;
    #1 chk_outs("rst_held", 0, 1, 0, 0, 32'h0, 32'h0);
    nRST = 1'b1;
    #1 chk_outs("rst_rel_idle", 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    #1 chk_outs("rst_regrant", 0, 0, 0, 1, 32'h80, 32'hDEADBEEF);

    // Both caches requesting continuously with the RAM always ready.
    @(negedge CLK);
    nRST = 1'b0;
    iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h200; ramstate = 2'd2;
    #1 nRST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic ew_i, ew_d;
      ew_i = 1'b1;
      ew_d = 1'b1;
      if (k % 2 == 1) begin
`ifdef MEMORY_ARBITER_FAIR_EN
        if (k % 4 == 1) ew_d = 1'b0;
        else ew_i = 1'b0;
`else
        ew_d = 1'b0;
`endif
      end
      #1;
      chk($sformatf("contend%0d iwait", k), {31'b0, iwait}, {31'b0, ew_i});
      chk($sformatf("contend%0d dwait", k), {31'b0, dwait}, {31'b0, ew_d});
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
